// File: rtl/soc_bus_pkg.sv
// Shared definitions for the slaves on the chip's master bus: bus width, slave IDs, MAC engine types.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package soc_bus_pkg;

    localparam int DATA_W  = 32;
    localparam int SLV_MAC = 0;
    localparam int SLV_FFT = 1;

    // MAC engine geometry
    localparam int N_WORDS = 8;
    localparam int CNT_W   = $clog2(N_WORDS);
    localparam int PROD_W  = 16;
    // 8 * 255 * 255 = 520200 fits in 20 bits
    localparam int ACC_W   = 20;

    typedef enum logic [1:0] {
        MAC_IDLE,
        MAC_ACC,
        MAC_DONE,
        MAC_REL
    } mac_state_t;

endpackage

// File: rtl/mac_mul8.sv
// 8x8 unsigned multiplier for the MAC engine, optionally registered (MAC_PIPE_EN).
// Latency: 0 cycles by default, 1 cycle with MAC_PIPE_EN defined.
// Backpressure: none; a new operand pair is accepted every cycle.
// Ports: clk, rst (async active-low), a/b operands, prod result.
module mac_mul8
    import soc_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic [PROD_W-1:0] prod
);

`ifdef MAC_PIPE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod <= '0;
        end else begin
            prod <= a * b;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign prod = a * b;
`endif

endmodule

// File: rtl/mac_slave.sv
// Bus slave 0: accumulates byte[15:8]*byte[7:0] over an 8-word burst, returns the sum with a 1-cycle ack.
// Latency: ack high between the 9th and 10th edge after the first sample (one edge later with MAC_PIPE_EN).
// Backpressure: none; one word is consumed per cycle while sel is high, dropping sel mid-burst aborts.
// Ports: clk, rst (async active-low), sel (granted and slave_id==0), s_data_in (bits [31:16] ignored),
//        s_data_out (result, zero unless ack), ack (result-valid pulse).
// Build option: MAC_PIPE_EN registers the multiplier output.
module mac_slave
    import soc_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_data_in,
    output logic [DATA_W-1:0] s_data_out,
    output logic              ack
);

`ifdef MAC_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    mac_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              ack_nxt;
    // set once the last registered product has been folded into acc
    logic              drain, drain_nxt;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;

    logic unused_hi;
    assign unused_hi = ^s_data_in[DATA_W-1:16];

    mac_mul8 u_mul (
        .clk  (clk),
        .rst  (rst),
        .a    (s_data_in[15:8]),
        .b    (s_data_in[7:0]),
        .prod (prod)
    );

    assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MAC_IDLE;
            cnt        <= '0;
            acc        <= '0;
            s_data_out <= '0;
            ack        <= 1'b0;
            drain      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            s_data_out <= dout_nxt;
            ack        <= ack_nxt;
            drain      <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        dout_nxt  = '0;
        ack_nxt   = 1'b0;
        drain_nxt = 1'b0;
        case (state)
            MAC_IDLE: begin
                cnt_nxt = '0;
                acc_nxt = '0;
                if (sel) begin
                    // with a registered multiplier word0's product arrives on the next edge
                    acc_nxt   = PIPE ? '0 : prod_ext;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = MAC_ACC;
                end
            end
            MAC_ACC: begin
                if (!sel) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = MAC_IDLE;
                end else begin
                    acc_nxt = acc + prod_ext;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N_WORDS - 1)) begin
                        state_nxt = MAC_DONE;
                    end
                end
            end
            MAC_DONE: begin
                // completes regardless of sel so a granted burst always gets its ack
                if (PIPE && !drain) begin
                    acc_nxt   = acc + prod_ext;
                    drain_nxt = 1'b1;
                end else begin
                    dout_nxt  = {{(DATA_W-ACC_W){1'b0}}, acc};
                    ack_nxt   = 1'b1;
                    state_nxt = MAC_REL;
                end
            end
            MAC_REL: begin
                acc_nxt = '0;
                cnt_nxt = '0;
                // wait for the grant to drop so the same grant cannot start a second burst
                if (!sel) begin
                    state_nxt = MAC_IDLE;
                end
            end
            default: begin
                state_nxt = MAC_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_slave.sv
// Self-checking bench for mac_slave: directed patterns, abort, reset, hold/release and random bursts.
// Latency: expected ack position 2 negedges after the 8th sample edge (3 with MAC_PIPE_EN).
// Backpressure: n/a.
module tb_mac_slave;

    localparam int NW = 8;
`ifdef MAC_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int WIN = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] s_data_in = '0;
    logic [31:0] s_data_out;
    logic        ack;

    int checks = 0;
    int failures = 0;

    logic [31:0] words [NW];
    int          obs_ack_cnt;
    int          obs_ack_cyc;
    logic [31:0] obs_ack_val;
    int          obs_zero_viol;

    mac_slave dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .s_data_in  (s_data_in),
        .s_data_out (s_data_out),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // reference: sum of upper-byte * lower-byte products of the low halfword
    function automatic logic [31:0] model_sum();
        int s = 0;
        for (int i = 0; i < NW; i++) begin
            s += int'(words[i][15:8]) * int'(words[i][7:0]);
        end
        return 32'(s);
    endfunction

    // Drives n_words with sel high (must be called #1 after a posedge with sel low),
    // keeps sel high for sel_hi negedges after the last sample, and records what ack did.
    task automatic drive_burst(input int n_words, input int sel_hi);
        obs_ack_cnt   = 0;
        obs_ack_cyc   = -1;
        obs_ack_val   = '0;
        obs_zero_viol = 0;
        sel = 1'b1;
        for (int i = 0; i < n_words; i++) begin
            s_data_in = words[i];
            @(posedge clk);
            #1;
        end
        s_data_in = $urandom;
        if (n_words < NW) sel = 1'b0;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                obs_ack_cnt++;
                if (obs_ack_cyc < 0) begin
                    obs_ack_cyc = k;
                    obs_ack_val = s_data_out;
                end
            end else if (s_data_out !== 32'h0) begin
                obs_zero_viol++;
            end
            if (k == sel_hi) sel = 1'b0;
        end
        sel = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sel = 1'b1;
        s_data_in = 32'h0000FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || s_data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b data=%h, need ack=0 data=0", ack, s_data_out);
        end
        sel = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || s_data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: ack=%b data=%h, need ack=0 data=0", ack, s_data_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_patterns();
        logic [31:0] pat [4];
        logic [31:0] exp_v [4];
        logic [31:0] e;
        pat[0] = 32'h00000203; exp_v[0] = 32'h00000030;
        pat[1] = 32'h0000FFFF; exp_v[1] = 32'h0007F008;
        pat[2] = 32'hABCD0102; exp_v[2] = 32'h00000010;
        pat[3] = 32'hFFFF0000; exp_v[3] = 32'h00000000;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < NW; i++) words[i] = pat[p];
            e = model_sum();
            checks++;
            if (e !== exp_v[p]) begin
                failures++;
                $display("FAIL model_pattern%0d: model=%h, table=%h", p, e, exp_v[p]);
            end
            drive_burst(NW, 1 + p);
            checks++;
            if (obs_ack_cnt != 1 || obs_ack_cyc != LAT) begin
                failures++;
                $display("FAIL pattern%0d_ack: pulses=%0d at cycle %0d, need 1 at %0d", p, obs_ack_cnt, obs_ack_cyc, LAT);
            end
            checks++;
            if (obs_ack_val !== exp_v[p]) begin
                failures++;
                $display("FAIL pattern%0d_data: got %h, need %h", p, obs_ack_val, exp_v[p]);
            end
            checks++;
            if (obs_zero_viol != 0) begin
                failures++;
                $display("FAIL pattern%0d_zero: %0d non-zero cycles without ack, need 0", p, obs_zero_viol);
            end
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < NW; i++) words[i] = 32'h0000FFFF;
        drive_burst(4, 0);
        checks++;
        if (obs_ack_cnt != 0 || obs_zero_viol != 0) begin
            failures++;
            $display("FAIL abort_no_ack: pulses=%0d nonzero=%0d, need 0 and 0", obs_ack_cnt, obs_zero_viol);
        end
        for (int i = 0; i < NW; i++) words[i] = 32'h00000101;
        drive_burst(NW, 2);
        checks++;
        if (obs_ack_cnt != 1 || obs_ack_cyc != LAT || obs_ack_val !== 32'h8) begin
            failures++;
            $display("FAIL abort_next: pulses=%0d cycle=%0d data=%h, need 1 at %0d data 00000008",
                     obs_ack_cnt, obs_ack_cyc, obs_ack_val, LAT);
        end
    endtask

    task automatic test_reset_mid();
        // reset after word 5 of a burst
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data_in = 32'h0000FFFF;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || s_data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_burst: ack=%b data=%h, need 0/0", ack, s_data_out);
        end
        sel = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        // reset while the ack pulse is being presented must clear it immediately
        for (int i = 0; i < NW; i++) words[i] = 32'h00000505;
        sel = 1'b1;
        for (int i = 0; i < NW; i++) begin
            s_data_in = words[i];
            @(posedge clk);
            #1;
        end
        repeat (LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (ack !== 1'b1 || s_data_out !== 32'h000000C8) begin
            failures++;
            $display("FAIL reset_pre_ack: ack=%b data=%h, need 1/000000c8", ack, s_data_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || s_data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_during_ack: ack=%b data=%h, need 0/0", ack, s_data_out);
        end
        sel = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NW; i++) words[i] = 32'h00000303;
        drive_burst(NW, 1);
        checks++;
        if (obs_ack_cnt != 1 || obs_ack_cyc != LAT || obs_ack_val !== 32'h48) begin
            failures++;
            $display("FAIL reset_next: pulses=%0d cycle=%0d data=%h, need 1 at %0d data 00000048",
                     obs_ack_cnt, obs_ack_cyc, obs_ack_val, LAT);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NW; i++) words[i] = 32'h00000402;
        drive_burst(NW, LAT + 5);
        checks++;
        if (obs_ack_cnt != 1 || obs_ack_val !== 32'h40) begin
            failures++;
            $display("FAIL hold_single_ack: pulses=%0d data=%h, need 1 and 00000040", obs_ack_cnt, obs_ack_val);
        end
        for (int i = 0; i < NW; i++) words[i] = 32'h00001011;
        drive_burst(NW, 1);
        checks++;
        if (obs_ack_cnt != 1 || obs_ack_cyc != LAT || obs_ack_val !== 32'h880) begin
            failures++;
            $display("FAIL rearm_second: pulses=%0d cycle=%0d data=%h, need 1 at %0d data 00000880",
                     obs_ack_cnt, obs_ack_cyc, obs_ack_val, LAT);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < NW; i++) words[i] = $urandom;
            e = model_sum();
            drive_burst(NW, $urandom_range(1, 10));
            checks++;
            if (obs_ack_cnt != 1 || obs_ack_cyc != LAT || obs_ack_val !== e || obs_zero_viol != 0) begin
                failures++;
                $display("FAIL random%0d: pulses=%0d cycle=%0d data=%h nonzero=%0d, need 1 at %0d data %h nonzero 0",
                         b, obs_ack_cnt, obs_ack_cyc, obs_ack_val, obs_zero_viol, LAT, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_slave.md
Name: mac_slave

Overview:
- Slave 0 on the chip's shared master bus: the multiply-accumulate engine reached when the arbiter grants a master whose slave_id is 0.
- Consumes a burst of 8 32-bit words from the granted master.
- Per word, multiplies byte [15:8] by byte [7:0], unsigned, and accumulates all 8 products.
- Returns the sum on the bus with a one-cycle ack pulse. Sits directly downstream of the arbiter/bus mux, in parallel with the FFT slave.

Parameters:
- N_WORDS, 8, words per burst (counter width = $clog2(N_WORDS)).
- DATA_W, 32, bus word width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
- sel  in  1  slave select: a master is granted and its slave_id == 0; from the bus decoder.
- s_data_in  in  DATA_W  muxed master write data (bits [31:16] ignored).
- s_data_out  out  DATA_W  result to bus read mux.
- ack  out  1  result-valid pulse.

Behaviour:
- Reset values (async, rst=0): state=IDLE, cnt=0, acc=0, s_data_out=0, ack=0.
- States: IDLE, ACC, DONE, REL.
- IDLE:
  - sel=0: stay in IDLE.
  - sel=1 at a rising edge: that edge samples word0; acc <= prod(word0); cnt <= 1; go to ACC.
- ACC:
  - each edge: acc <= acc + prod(word); cnt++.
  - the edge that samples word N_WORDS-1 goes to DONE.
- DONE:
  - edge: s_data_out <= acc, ack <= 1, go to REL.
- REL:
  - edge: ack <= 0, s_data_out <= 0, acc <= 0, cnt <= 0.
  - stay in REL while sel=1; go to IDLE once sel=0. This prevents re-triggering on the same grant.
- Latency: word0 sampled at edge E1, word7 at E8, ack high for exactly one cycle between E9 and E10. Masters sample the result on the negedge inside that window.
- Arithmetic:
  - prod = s_data_in[15:8] * s_data_in[7:0], unsigned, 16 bits.
  - acc is 20 bits; the maximum 8*255*255 = 520200 cannot overflow.
  - s_data_out = {12'b0, acc}.
- s_data_out is 0 whenever ack=0.
- sel drops while in ACC: abort to IDLE, clear acc/cnt, no ack.
- sel drops in DONE: still complete DONE→REL (ack pulses once), then IDLE.
- rst asserted mid-burst: immediate clear to reset values. A burst in progress is lost and the master never sees ack.
- Back-to-back grants: a new burst can start only after passing through IDLE (at least one cycle with sel=0).

Optional Feature:
- MAC_PIPE_EN defined:
  - registered multiplier output; the accumulator adds the product one edge later.
  - ack and result move one cycle later (ack high between E10 and E11).
  - state DONE waits one extra edge for the final product.
- Not defined: combinational multiply feeding acc, latency as above.

Decomposition:
- Package soc_bus_pkg: DATA_W, slave ID constants (SLV_MAC=0, SLV_FFT=1), mac state enum type, product/accumulator width constants (PROD_W=16, ACC_W=20).
- Sub-module mac_mul8: 8x8 unsigned multiplier; holds the optional pipeline register under MAC_PIPE_EN.

Test Plan:
- Basic: sel=1, 8 words 0x00000203 → ack one cycle after 8th sample, s_data_out=0x00000030; s_data_out=0 before and after.
- Max operands: 8 words 0x0000FFFF → s_data_out=0x0007F008, no overflow.
- Upper bits ignored: 8 words 0xABCD0102 → 0x00000010.
- Abort: drop sel after 4 words → no ack, state IDLE; new burst of 8×0x00000101 → 0x00000008 (no stale acc).
- Reset mid-burst: rst=0 after word 5 → ack=0 and s_data_out=0 immediately (async); after release, a full burst of 0x00000303 → 0x00000048.
- Hold/release: sel held 5 cycles after ack → exactly one ack pulse; re-raise sel after one low cycle → second burst accepted. Repeat the whole suite with MAC_PIPE_EN defined and check the +1 cycle ack.
